// File: rtl/amf_stream.sv
// amf_stream: streaming 3x3 window filter for raster pixels.
// Two line buffers plus a shifting 3x3 window feed a three-stage registered
// pipeline (window snapshot, per-row sort, mode select). A single global
// enable stalls every register, including line buffers and counters, whenever
// the output holds a pixel that downstream has not yet taken.
module amf_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 640
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_sof,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    localparam int              CW       = $clog2(IMG_W);
    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0]   COL_TWO  = CW'(2);
    localparam logic [CW-1:0]   COL_ONE  = CW'(1);
    localparam logic [1:0]      ROW_FULL = 2'd2;

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DW-1:0] min3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [DW-1:0] max3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    // Median of three: the larger of min(a,b) and min(max(a,b), c).
    function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Line buffers: lb1 = previous line, lb0 = the line before it (not reset).
    logic [DW-1:0] lb0_q [IMG_W];
    logic [DW-1:0] lb1_q [IMG_W];

    logic                   en_s;
    logic                   acc_s;
    logic                   emit_s;
    logic [CW-1:0]          pcol_s;
    logic [1:0]             prow_s;
    logic [DW-1:0]          lb0_rd_s;
    logic [DW-1:0]          lb1_rd_s;
    logic [DW-1:0]          res_s;

    // Position of the next pixel (unless it carries s_sof).
    logic [CW-1:0]          col_q, col_d;
    logic [1:0]             row_q, row_d;

    // Shifting window, [row][col], row 0 = top, col 2 = newest.
    logic [2:0][2:0][DW-1:0] win_q, win_d;
    logic                   w_valid_q, w_valid_d;
    logic [1:0]             w_mode_q, w_mode_d;

    // S1: window snapshot.
    logic [2:0][2:0][DW-1:0] s1_win_q, s1_win_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [1:0]             s1_mode_q, s1_mode_d;

    // S2: per-row min/med/max plus centre.
    logic [2:0][DW-1:0]     s2_min_q, s2_min_d;
    logic [2:0][DW-1:0]     s2_med_q, s2_med_d;
    logic [2:0][DW-1:0]     s2_max_q, s2_max_d;
    logic [DW-1:0]          s2_ctr_q, s2_ctr_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [1:0]             s2_mode_q, s2_mode_d;

    // S3: output register.
    logic                   m_valid_q, m_valid_d;
    logic [DW-1:0]          m_data_q, m_data_d;

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    // Handshake, pixel position, line buffer read and window shift.
    always_comb begin
        en_s      = !m_valid_q || m_ready;
        s_ready   = en_s;
        acc_s     = s_valid && en_s;
        if (s_sof) begin
            pcol_s = {CW{1'b0}};
            prow_s = 2'd0;
        end else begin
            pcol_s = col_q;
            prow_s = row_q;
        end
        emit_s    = (prow_s == ROW_FULL) && (pcol_s >= COL_TWO);
        lb0_rd_s  = lb0_q[pcol_s];
        lb1_rd_s  = lb1_q[pcol_s];

        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        w_valid_d = w_valid_q;
        w_mode_d  = w_mode_q;

        if (en_s) begin
            if (acc_s) begin
                if (pcol_s == COL_LAST) begin
                    col_d = {CW{1'b0}};
                    row_d = (prow_s == ROW_FULL) ? ROW_FULL : prow_s + 2'd1;
                end else begin
                    col_d = pcol_s + COL_ONE;
                    row_d = prow_s;
                end
                for (int r = 0; r < 3; r++) begin
                    win_d[r][0] = win_q[r][1];
                    win_d[r][1] = win_q[r][2];
                end
                win_d[0][2] = lb0_rd_s;
                win_d[1][2] = lb1_rd_s;
                win_d[2][2] = s_data;
                w_valid_d   = emit_s;
                w_mode_d    = mode;
            end else begin
                w_valid_d   = 1'b0;
            end
        end else begin
            w_valid_d = w_valid_q;
        end
    end

    // Pipeline stages S1..S3; every stage holds while stalled.
    always_comb begin
        s1_win_d   = s1_win_q;
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s2_min_d   = s2_min_q;
        s2_med_d   = s2_med_q;
        s2_max_d   = s2_max_q;
        s2_ctr_d   = s2_ctr_q;
        s2_valid_d = s2_valid_q;
        s2_mode_d  = s2_mode_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;

        case (s2_mode_q)
            2'b00:   res_s = med3(s2_med_q[0], s2_med_q[1], s2_med_q[2]);
            2'b01:   res_s = min3(s2_min_q[0], s2_min_q[1], s2_min_q[2]);
            2'b10:   res_s = max3(s2_max_q[0], s2_max_q[1], s2_max_q[2]);
            2'b11:   res_s = s2_ctr_q;
            default: res_s = s2_ctr_q;
        endcase

        if (en_s) begin
            s1_win_d   = win_q;
            s1_valid_d = w_valid_q;
            s1_mode_d  = w_mode_q;
            for (int r = 0; r < 3; r++) begin
                s2_min_d[r] = min3(s1_win_q[r][0], s1_win_q[r][1], s1_win_q[r][2]);
                s2_med_d[r] = med3(s1_win_q[r][0], s1_win_q[r][1], s1_win_q[r][2]);
                s2_max_d[r] = max3(s1_win_q[r][0], s1_win_q[r][1], s1_win_q[r][2]);
            end
            s2_ctr_d   = s1_win_q[1][1];
            s2_valid_d = s1_valid_q;
            s2_mode_d  = s1_mode_q;
            m_valid_d  = s2_valid_q;
            if (s2_valid_q) begin
                m_data_d = res_s;
            end else begin
                m_data_d = m_data_q;
            end
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Line buffer update on accept; the old lb1 entry moves down into lb0.
    always_ff @(posedge clk) begin
        if (acc_s) begin
            lb0_q[pcol_s] <= lb1_rd_s;
            lb1_q[pcol_s] <= s_data;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= {CW{1'b0}};
            row_q      <= 2'd0;
            win_q      <= {(9 * DW){1'b0}};
            w_valid_q  <= 1'b0;
            w_mode_q   <= 2'd0;
            s1_win_q   <= {(9 * DW){1'b0}};
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 2'd0;
            s2_min_q   <= {(3 * DW){1'b0}};
            s2_med_q   <= {(3 * DW){1'b0}};
            s2_max_q   <= {(3 * DW){1'b0}};
            s2_ctr_q   <= {DW{1'b0}};
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 2'd0;
            m_valid_q  <= 1'b0;
            m_data_q   <= {DW{1'b0}};
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            win_q      <= win_d;
            w_valid_q  <= w_valid_d;
            w_mode_q   <= w_mode_d;
            s1_win_q   <= s1_win_d;
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s2_min_q   <= s2_min_d;
            s2_med_q   <= s2_med_d;
            s2_max_q   <= s2_max_d;
            s2_ctr_q   <= s2_ctr_d;
            s2_valid_q <= s2_valid_d;
            s2_mode_q  <= s2_mode_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
        end
    end

endmodule

// File: doc/amf_stream.md
# amf_stream

Streaming, parametrised approximate median filter for raster pixel data. It accepts one pixel per cycle over a valid/ready handshake and keeps two line buffers plus a 3x3 window. It emits one filtered pixel for every fully-interior 3x3 window, through a registered pipeline with global back-pressure. It sits between the pixel source and downstream image stages, and replaces the fixed 8-bit combinational window filter with a runtime-selectable mode.

## Interface
- DW, 8, pixel width in bits (≥2)
- IMG_W, 640, line width in pixels (≥3); line buffer depth
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  2  filter mode, sampled with each accepted pixel: 00 approx median, 01 window min, 10 window max, 11 centre bypass
- s_valid  in  1  input pixel valid
- s_ready  out  1  block can accept a pixel
- s_sof  in  1  first pixel of frame, qualified by s_valid
- s_data  in  DW  input pixel, unsigned
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts output
- m_data  out  DW  filtered pixel

## Operation
- Accept occurs when s_valid && s_ready.
- Position counters are `col` (0..IMG_W-1) and `row` (saturates at 2).
- On an accept:
  - If s_sof, the pixel takes col=0, row=0.
  - Otherwise col increments. Wrap at IMG_W-1 → col=0, row=min(row+1,2).
- Line buffers:
  - lb1 holds the previous line; lb0 holds the line before that. Both are indexed by col and use read-before-write.
  - On each accept: the window shifts left one column, and the new right column is {lb0[col], lb1[col], s_data}, top to bottom.
  - Then lb0[col]←lb1[col] and lb1[col]←s_data.
- Window emission:
  - A window is emitted iff row==2 and col≥2, both at the pixel being accepted.
  - Other accepts update state only and produce no output.
  - Each frame of H lines yields (H-2)(IMG_W-2) outputs.
- Modes (all comparisons unsigned, results exactly DW bits, no rounding):
  - 00: median of the three row medians, where each row median is the median of 3.
  - 01: min of 9.
  - 10: max of 9.
  - 11: centre pixel.
- Pipeline stages:
  - S1: window and mode registered.
  - S2: per-row min/med/max registered.
  - S3: result registered into m_data/m_valid.
- Each stage carries a valid bit and the mode. Mode changes mid-frame take effect per pixel.
- Back-pressure:
  - Stall is global: enable = !m_valid || m_ready, and s_ready = enable.
  - While stalled, every register including the line buffers and counters holds.
  - m_data stays stable while m_valid && !m_ready.
- Reset (async assert, sync release):
  - m_valid=0, m_data=0, all stage valids=0, col=0, row=0, s_ready=1 after release.
  - Line buffer contents are not cleared; row gating makes them don't-care.
  - Reset mid-frame drops in-flight pixels. The next frame must begin with s_sof.
- s_sof mid-line restarts counters at that pixel; partial-line windows are never emitted.

## Timing
- Latency is 3 cycles: the window-completing pixel accepted at edge N gives m_valid=1 with its m_data after edge N+3, provided no stall occurs.
- Throughput is 1 pixel/cycle when m_ready is held high.
- s_ready is combinational from m_ready and m_valid; no other input-to-output combinational path exists.
- An accepted pixel and an output handshake in the same cycle are both honoured.
- s_sof together with stall: the beat is not accepted, and s_sof must be held with its pixel.

## Test plan
- IMG_W=3, mode=00, one frame with rows {10,200,30},{90,5,60},{70,80,40} and m_ready=1 → exactly one output, m_data=60, m_valid high for 1 cycle, 3 cycles after the 9th accept.
- The same frame repeated with mode=01, 10, 11 → m_data=5, 200, 5 respectively, one output each.
- IMG_W=4, 5-line frame of incrementing pixels (p=r*4+c), mode=11 → 6 outputs equal to centres 5,6,9,10,13,14 in order. No output during lines 0–1 or at col<2.
- Same stream with m_ready toggling 1/0 every 2 cycles and random s_valid gaps → identical output sequence, m_data stable during stalls, s_ready low exactly when m_valid && !m_ready.
- Assert rst_n=0 mid-frame after 6 accepts, then start a new frame with s_sof → m_valid=0 immediately at reset, and outputs match a clean run of the new frame.
- DW=12, all pixels 4095 except one 0 per window, mode=00 → every output is 4095. With a 0 in every row centre column → outputs are 4095 (approx median).
